// File: rtl/balance_reader.sv
// balance_reader: snapshots a packed word of account balances from RAM, streams
// each balance over a valid/ready handshake with a changed-since-last-pass flag,
// and publishes the pass total together with a one-cycle done pulse.
module balance_reader #(
   parameter int NUM_ACCOUNTS = 6,
   parameter int BAL_WIDTH    = 8,
   parameter int SUM_WIDTH    = 11
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic                              start,
   input  logic [NUM_ACCOUNTS*BAL_WIDTH-1:0] memory_values,
   output logic                              busy,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [2:0]                        out_index,
   output logic [BAL_WIDTH-1:0]              out_balance,
   output logic                              out_changed,
   output logic                              out_last,
   output logic [SUM_WIDTH-1:0]              total,
   output logic                              done
);

   localparam int WORD_W = NUM_ACCOUNTS * BAL_WIDTH;
   localparam logic [2:0] LAST_IDX = 3'(NUM_ACCOUNTS - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CAPTURE,
      S_EMIT,
      S_DONE
   } state_t;

   state_t                 r_state;
   state_t                 w_state_next;
   logic [WORD_W-1:0]      r_snap;
   logic [WORD_W-1:0]      r_prev;
   logic [2:0]             r_index;
   logic [SUM_WIDTH-1:0]   r_acc;
   logic [SUM_WIDTH-1:0]   r_total;
   logic [NUM_ACCOUNTS-1:0] w_diff;
   logic [BAL_WIDTH-1:0]   w_cur_bal;
   logic                   w_is_last;
   logic                   w_xfer;

   // Per-account comparison of the current snapshot against the previous pass.
   generate
      for (genvar gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_diff
         assign w_diff[gi] = r_snap[gi*BAL_WIDTH +: BAL_WIDTH] != r_prev[gi*BAL_WIDTH +: BAL_WIDTH];
      end
   endgenerate

   // Index never exceeds NUM_ACCOUNTS-1, so the slice stays inside the snapshot.
   assign w_cur_bal = r_snap[r_index*BAL_WIDTH +: BAL_WIDTH];
   assign w_is_last = (r_index == LAST_IDX);
   assign w_xfer    = (r_state == S_EMIT) && out_ready;

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and state-decoded outputs; data outputs read zero outside EMIT.
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      out_valid    = 1'b0;
      out_index    = 3'd0;
      out_balance  = '0;
      out_changed  = 1'b0;
      out_last     = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            busy         = 1'b1;
            w_state_next = S_EMIT;
         end
         S_EMIT: begin
            busy        = 1'b1;
            out_valid   = 1'b1;
            out_index   = r_index;
            out_balance = w_cur_bal;
            out_changed = w_diff[r_index];
            out_last    = w_is_last;
            if (out_ready && w_is_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            busy         = 1'b1;
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Snapshot capture, index/accumulator stepping, and end-of-pass commit.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_snap  <= '0;
         r_prev  <= '0;
         r_index <= 3'd0;
         r_acc   <= '0;
         r_total <= '0;
      end else begin
         if (r_state == S_CAPTURE) begin
            r_snap  <= memory_values;
            r_index <= 3'd0;
            r_acc   <= '0;
         end
         if (w_xfer) begin
            r_acc <= r_acc + {{(SUM_WIDTH-BAL_WIDTH){1'b0}}, w_cur_bal};
            if (!w_is_last) begin
               r_index <= r_index + 3'd1;
            end
         end
         if (r_state == S_DONE) begin
            r_total <= r_acc;
            r_prev  <= r_snap;
         end
      end
   end

   assign total = r_total;

endmodule

// File: doc/balance_reader.md
Name: balance_reader

Overview:
- Read-side counterpart to the memory controller's RAM writes.
- On request, waits out the RAM read latency, then snapshots the 48-bit account word from RAM (NUM_ACCOUNTS packed balances).
- Streams the balances one at a time over a valid/ready handshake to the display/draw engine. Each item is flagged if it changed since the previous read.
- Reports a total of all balances and a one-cycle done pulse at the end of each pass.

Parameters:
- NUM_ACCOUNTS, 6, number of packed balances in the RAM word.
- BAL_WIDTH, 8, bits per balance.
- SUM_WIDTH, 11, width of the running total; must satisfy 2^SUM_WIDTH > NUM_ACCOUNTS*(2^BAL_WIDTH-1).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a read pass; sampled only in IDLE.
- memory_values  input  NUM_ACCOUNTS*BAL_WIDTH  RAM read data. Account i occupies bits [i*BAL_WIDTH +: BAL_WIDTH].
- busy  output  1  high from the cycle after start is accepted until done has pulsed.
- out_valid  output  1  current item is valid.
- out_ready  input  1  consumer accepts the item.
- out_index  output  3  account number of the current item, 0..NUM_ACCOUNTS-1.
- out_balance  output  BAL_WIDTH  balance of the current item.
- out_changed  output  1  current balance differs from the same account in the previous completed pass.
- out_last  output  1  current item is account NUM_ACCOUNTS-1.
- total  output  SUM_WIDTH  sum of all balances from the last completed pass.
- done  output  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset (async, any state): go to IDLE. busy, out_valid, out_index, out_balance, out_changed, out_last, total, done all = 0. Snapshot and previous-snapshot registers = 0.
- State IDLE:
  - busy = 0.
  - start = 1 at edge -> CAPTURE.
  - start is ignored in every other state; no queuing.
- State CAPTURE (exactly 1 cycle, absorbs the registered RAM read):
  - busy = 1.
  - At the exiting edge: load snapshot <= memory_values; clear index and accumulator -> EMIT.
- State EMIT:
  - out_valid = 1.
  - out_balance = snapshot[index]; out_index = index.
  - out_last = (index == NUM_ACCOUNTS-1).
  - out_changed = snapshot[index] != prev[index].
  - Transfer occurs on an edge where out_valid && out_ready.
  - On transfer: accumulator += out_balance, zero-extended to SUM_WIDTH.
    - If not last: index++.
    - If last -> DONE.
  - Without out_ready, all outputs hold stable; no item is dropped or repeated.
  - First item is valid 2 cycles after the start edge. With out_ready tied high, one item transfers per cycle.
- State DONE (1 cycle):
  - done = 1; out_valid = 0.
  - At the exiting edge: total <= accumulator; prev <= snapshot -> IDLE.
  - total changes only here and holds until the next completed pass.
- Changes to memory_values after CAPTURE do not affect the pass in progress.
- Reset during a pass aborts it. prev and total are cleared, so the first pass after reset flags every nonzero balance as changed.
- Minimum pass length with out_ready = 1: 1 (CAPTURE) + NUM_ACCOUNTS (EMIT) + 1 (DONE) = 8 cycles. A start seen in IDLE the cycle after DONE begins a new pass immediately.
- No arithmetic overflow: SUM_WIDTH is sized for the all-max case (6*255 = 1530 < 2048).

Test Plan:
- Basic pass: memory_values = 0x060504030201, out_ready = 1, pulse start.
  - Required: items (index, balance) = (0,1) (1,2) (2,3) (3,4) (4,5) (5,6) on consecutive cycles, first item 2 cycles after start.
  - out_last only on index 5; all out_changed = 1; done pulses one cycle later; total = 21.
- Backpressure: same data, out_ready toggles 1,0,0,1,...
  - Required: each item held stable while out_ready = 0; exactly 6 transfers; total = 21.
- Snapshot isolation and start while busy: change memory_values to all 0xFF during EMIT, and pulse start mid-pass.
  - Required: the pass still emits 1..6; no extra pass begins.
  - A second start after done captures 0xFF×6: total = 1530, all out_changed = 1.
- Change detection: pass with 0x060504030201, then a pass with 0x060504030901.
  - Required: in the second pass only index 1 (balance 9) has out_changed = 1; total = 28.
- Reset mid-operation: assert reset asynchronously during EMIT index 3.
  - Required: all outputs 0 immediately without waiting for a clock edge; state IDLE.
  - A following pass on 0x060504030201 flags all 6 items as changed; total = 21.
- Zero word: memory_values = 0.
  - Required: 6 items of balance 0; out_changed = 0 after a previous all-zero pass; total = 0; done pulses once.
